// File: rtl/wbs_mem_responder.sv
// rtl/wbs_mem_responder.sv - Wishbone classic slave backed by a small word memory
// with programmable wait states and an out-of-range access counter.
module wbs_mem_responder #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h3000_0000,
    parameter int                    WAIT_STATES = 1
) (
`ifdef USE_POWER_PINS
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  o_busy,
    output logic [7:0]            o_err_cnt
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES - 1);

    // S_ACK is the cycle whose closing edge raises wb_ack_o and commits the access.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] rdat_q;
    logic                  ack_q;
    logic                  busy_q;
    logic [7:0]            err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  req_d;
    logic [ADDR_WIDTH-1:0] off_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  hit_d;

    assign req_d = wb_cyc_i && wb_stb_i;
    assign off_d = adr_q - BASE_ADDR;
    assign idx_d = off_d[IDX_W+1:2];
    // BASE_ADDR is DEPTH*4 aligned, so alignment and window tests work on the offset.
    assign hit_d = (adr_q >= BASE_ADDR) && (off_d[1:0] == 2'b00)
                && (off_d[ADDR_WIDTH-1:IDX_W+2] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        adr_q  <= wb_adr_i;
                        we_q   <= wb_we_i;
                        wdat_q <= wb_dat_i;
                        busy_q <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q <= S_ACK;
                        end else begin
                            cnt_q   <= WS_LOAD;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_d) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == 3'd0) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
                    if (hit_d) begin
                        if (we_q) begin
                            mem_q[idx_d] <= wdat_q;
                        end else begin
                            rdat_q <= mem_q[idx_d];
                        end
                    end else if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;
    assign o_busy    = busy_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_wbs_mem_responder.sv
// tb/tb_wbs_mem_responder.sv - self-checking bench for wbs_mem_responder
// driving three instances with 0, 1 and 3 wait states.
module tb_wbs_mem_responder;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        ack  [3];
    logic        busy [3];
    logic [7:0]  errc [3];

    logic [31:0] mdl  [3][DEPTH];
    int          merr [3];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] a;
        logic [31:0] dt;
        logic [31:0] exp_rd;
        logic [7:0]  exp_err;
    } vec_t;

    always #5 clk = ~clk;

    wbs_mem_responder #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]),
        .o_busy(busy[0]), .o_err_cnt(errc[0])
    );
    wbs_mem_responder #(.WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]),
        .o_busy(busy[1]), .o_err_cnt(errc[1])
    );
    wbs_mem_responder #(.WAIT_STATES(3)) u2 (
        .clk(clk), .rst(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
        .wb_adr_i(adr[2]), .wb_dat_i(wdat[2]), .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]),
        .o_busy(busy[2]), .o_err_cnt(errc[2])
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && ((off % 4) == 0) && ((off / 4) < DEPTH);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            merr[d] = 0;
            for (int i = 0; i < DEPTH; i++) mdl[d][i] = 32'h0;
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'h0; wdat[d] = 32'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ack_d%0d", d), {31'b0, ack[d]}, 32'h0);
            check($sformatf("rst_busy_d%0d", d), {31'b0, busy[d]}, 32'h0);
            check($sformatf("rst_dat_d%0d", d), rdat[d], 32'h0);
            check($sformatf("rst_err_d%0d", d), {24'b0, errc[d]}, 32'h0);
        end
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction; the expected ack latency and data come from the model.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dt,
                        output logic [31:0] got_rd, output logic [7:0] got_err);
        int          ws;
        bit          hit;
        int          idx;
        logic [31:0] exp_rd;
        ws     = ws_of(d);
        hit    = in_range(a);
        idx    = hit ? int'((a - BASE) >> 2) : 0;
        exp_rd = (hit && !w) ? mdl[d][idx] : 32'h0;
        if (hit && w) mdl[d][idx] = dt;
        if (!hit && merr[d] < 255) merr[d]++;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dt;
        @(posedge clk);
        #1;
        we[d] = ~w; adr[d] = ~a; wdat[d] = ~dt;
        for (int j = 0; j <= ws; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("wait_d%0d_j%0d ack,busy", d, j), {30'b0, ack[d], busy[d]}, 32'h1);
        end
        @(posedge clk);
        #1;
        check($sformatf("ack_d%0d ack,busy", d), {30'b0, ack[d], busy[d]}, 32'h2);
        got_rd  = rdat[d];
        got_err = errc[d];
        if (!w) check($sformatf("rdata_d%0d_%h", d, a), rdat[d], exp_rd);
        check($sformatf("errcnt_d%0d", d), {24'b0, errc[d]}, merr[d]);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("ack_pulse_d%0d", d), {31'b0, ack[d]}, 32'h0);
        check($sformatf("dat_idle_d%0d", d), rdat[d], 32'h0);
    endtask

    vec_t        vt [15];
    logic [31:0] rd;
    logic [7:0]  ec;
    bit          seen;
    logic [31:0] ra;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        clear_model();

        vt[0]  = '{1, 1'b0, 32'h3000_0010, 32'h0,         32'h0,         8'd0};
        vt[1]  = '{1, 1'b1, 32'h3000_0008, 32'hCAFE_F00D, 32'h0,         8'd0};
        vt[2]  = '{1, 1'b0, 32'h3000_0008, 32'h0,         32'hCAFE_F00D, 8'd0};
        vt[3]  = '{1, 1'b1, 32'h3000_0100, 32'h1234_5678, 32'h0,         8'd1};
        vt[4]  = '{1, 1'b1, 32'h3000_0002, 32'h1234_5678, 32'h0,         8'd2};
        vt[5]  = '{1, 1'b0, 32'h3000_0000, 32'h0,         32'h0,         8'd2};
        vt[6]  = '{1, 1'b1, 32'h3000_00FC, 32'hAABB_CCDD, 32'h0,         8'd2};
        vt[7]  = '{1, 1'b0, 32'h3000_00FC, 32'h0,         32'hAABB_CCDD, 8'd2};
        vt[8]  = '{1, 1'b0, 32'h2FFF_FFFC, 32'h0,         32'h0,         8'd3};
        vt[9]  = '{1, 1'b0, 32'h3000_0008, 32'h0,         32'hCAFE_F00D, 8'd3};
        vt[10] = '{0, 1'b1, 32'h3000_0004, 32'h0F0F_5A5A, 32'h0,         8'd0};
        vt[11] = '{0, 1'b0, 32'h3000_0004, 32'h0,         32'h0F0F_5A5A, 8'd0};
        vt[12] = '{2, 1'b1, 32'h3000_00F8, 32'h8765_4321, 32'h0,         8'd0};
        vt[13] = '{2, 1'b0, 32'h3000_00F8, 32'h0,         32'h8765_4321, 8'd0};
        vt[14] = '{2, 1'b0, 32'h3000_0103, 32'h0,         32'h0,         8'd1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            xfer(vt[i].d, vt[i].w, vt[i].a, vt[i].dt, rd, ec);
            if (!vt[i].w) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_errcnt", i), {24'b0, ec}, {24'b0, vt[i].exp_err});
        end

        // Master drops cyc during the wait window.
        do_reset();
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h3000_0008; wdat[2] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("abort_busy_on", {31'b0, busy[2]}, 32'h1);
        cyc[2] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack[2]) seen = 1'b1;
        end
        check("abort_no_ack", {31'b0, seen}, 32'h0);
        check("abort_busy_off", {31'b0, busy[2]}, 32'h0);
        stb[2] = 1'b0;
        xfer(2, 1'b0, 32'h3000_0008, 32'h0, rd, ec);
        check("abort_word", rd, 32'h0);
        check("abort_err", {24'b0, ec}, 32'h0);

        // Classic back-to-back reads with stb held, zero wait states.
        xfer(0, 1'b1, 32'h3000_0000, 32'h1111_AAAA, rd, ec);
        xfer(0, 1'b1, 32'h3000_0004, 32'h2222_BBBB, rd, ec);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h3000_0000;
        @(posedge clk);
        #1;
        check("b2b_ack0_low", {31'b0, ack[0]}, 32'h0);
        @(posedge clk);
        #1;
        check("b2b_ack0_high", {31'b0, ack[0]}, 32'h1);
        check("b2b_dat0", rdat[0], 32'h1111_AAAA);
        adr[0] = 32'h3000_0004;
        @(posedge clk);
        #1;
        check("b2b_ack1_low", {31'b0, ack[0]}, 32'h0);
        check("b2b_gap_dat", rdat[0], 32'h0);
        @(posedge clk);
        #1;
        check("b2b_ack1_high", {31'b0, ack[0]}, 32'h1);
        check("b2b_dat1", rdat[0], 32'h2222_BBBB);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ack_end", {31'b0, ack[0]}, 32'h0);

        // Reset pulsed while a write sits in its wait window.
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h3000_0004; wdat[2] = 32'h1357_9BDF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rstw_busy", {31'b0, busy[2]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw_ack", {31'b0, ack[2]}, 32'h0);
        check("rstw_busy_clr", {31'b0, busy[2]}, 32'h0);
        check("rstw_dat", rdat[2], 32'h0);
        check("rstw_err", {24'b0, errc[2]}, 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack[2]) seen = 1'b1;
        end
        check("rstw_no_ack", {31'b0, seen}, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        clear_model();
        xfer(2, 1'b0, 32'h3000_0004, 32'h0, rd, ec);
        check("rstw_word1", rd, 32'h0);

        // Randomised traffic against the model on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 9))
                    0:       ra = BASE + 32'h100 + ($urandom_range(0, 63) << 2);
                    1:       ra = BASE + ($urandom_range(0, 63) << 2) + $urandom_range(1, 3);
                    2:       ra = BASE - ($urandom_range(1, 4) << 2);
                    default: ra = BASE + ($urandom_range(0, 7) << 2);
                endcase
                xfer(d, $urandom_range(0, 1) == 1, ra, $urandom, rd, ec);
            end
        end

        // Error counter saturation.
        for (int n = 0; n < 260; n++) begin
            xfer(0, 1'b1, BASE + 32'h200, $urandom, rd, ec);
        end
        check("err_saturated", {24'b0, errc[0]}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
